aes32_seq: RTL and testbench
============================

AES32_SEQ -- requirements
Module: aes32_seq

Interface
REQ-001 The block SHALL have parameter MIX_STAGE, default 1, meaning 1 = registered MixColumn stage and 0 = MixColumn folded into the SubBytes stage.
REQ-002 The block SHALL have port g_clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-003 The block SHALL have port g_resetn, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port valid, input, 1 bit: request present; inputs are held stable while valid && !ready.
REQ-005 The block SHALL have ports op_encs, op_encsm, op_decs and op_decsm, inputs, 1 bit each: encrypt SubBytes, encrypt SubBytes+MixColumn, decrypt SubBytes, decrypt SubBytes+MixColumn.
REQ-006 The block SHALL have ports rs1 and rs2, inputs, 32 bits each: source operands.
REQ-007 The block SHALL have port bs, input, 2 bits: byte select.
REQ-008 The block SHALL have port rd, output, 32 bits: result.
REQ-009 The block SHALL have port ready, output, 1 bit: result valid, one-cycle pulse.

Function
REQ-010 The input byte SHALL be b = rs2[8*bs+7:8*bs].
REQ-011 The S-box result SHALL be s = SBox(b) for encs/encsm and s = InvSBox(b) for decs/decsm, using one shared forward/inverse S-box instance.
REQ-012 The column word t SHALL be: encs/decs {24'h0,s}; encsm {3s,s,s,2s}; decsm {0b*s,0d*s,09*s,0e*s}; byte order [31:24]..[7:0]; multiplication in GF(2^8) mod 0x11B.
REQ-013 The result SHALL be rd = rs1 ^ rol32(t, 8*bs).
REQ-014 Zero or more than one op bit set with valid high SHALL give t = 0 (rd = rs1), completing with non-mix latency.
REQ-015 The FSM SHALL have states IDLE, SUB, MIX and DONE.
REQ-016 From IDLE, valid=1 SHALL go to SUB; otherwise the FSM SHALL stay in IDLE.
REQ-017 In SUB, s SHALL be registered; next state MIX if MIX_STAGE=1 and op is encsm/decsm, else DONE (with MIX_STAGE=0, t is computed combinationally from the SUB register).
REQ-018 In MIX, t SHALL be registered, then go to DONE.
REQ-019 In DONE, ready SHALL be 1 and rd SHALL be valid; next state IDLE unconditionally.
REQ-020 Latency SHALL be ready two cycles after valid is first sampled, or three cycles for mix ops when MIX_STAGE=1.
REQ-021 Throughput SHALL be at most one op per 3 or 4 cycles; valid still high in the cycle after DONE SHALL start a new op.
REQ-022 Outside DONE, rd SHALL be 32'h0 and ready SHALL be 0.
REQ-023 valid deasserted in SUB or MIX SHALL abort: the next state is IDLE and ready is not asserted.
REQ-024 Internal datapath registers SHALL load only in their own state, for logic gating.

Reset
REQ-025 g_resetn=0 at a clock edge SHALL force state IDLE and clear the s and t registers, giving ready=0 and rd=0 the following cycle.
REQ-026 Reset in any state, including mid-op, SHALL discard the op without asserting ready.

Configuration
REQ-027 With AES32_SEQ_DEC_EN defined, the inverse S-box and inverse MixColumn multipliers SHALL be built and decs/decsm SHALL behave per REQ-011/012.
REQ-028 Without AES32_SEQ_DEC_EN, decrypt logic SHALL be omitted and decs/decsm SHALL be treated as illegal per REQ-014 (rd = rs1, non-mix latency).

Verification (MIX_STAGE=1, AES32_SEQ_DEC_EN defined unless stated)
REQ-029 encs, rs1=0, rs2=0x00000053, bs=0 -> ready 2 cycles after valid, rd=0x000000ED.
REQ-030 encsm, rs1=0, rs2=0x00005300, bs=1 -> ready after 3 cycles, rd=0xEDEDC12C; with MIX_STAGE=0 -> same rd after 2 cycles.
REQ-031 decs, rs1=0xFFFFFFFF, rs2=0xED000000, bs=3 -> rd=0xACFFFFFF; same stimulus without macro -> rd=0xFFFFFFFF.
REQ-032 decsm, rs1=0, rs2=0x000000ED, bs=0 -> ready after 3 cycles, rd=0x5BAAFD5F.
REQ-033 Abort and reset: valid dropped in SUB -> IDLE next cycle with ready never high; g_resetn=0 in MIX -> ready=0 and rd=0 next cycle.
REQ-034 Back-to-back: encs held valid through DONE with new operands -> second ready exactly 3 cycles after the first; a formal equivalence bench against the single-cycle golden model SHALL check rd on every valid && ready.

Source files
------------

// File: rtl/aes32_seq.sv
// aes32_seq: multi-cycle AES SubBytes / SubBytes+MixColumn on one selected byte of rs2, xored into rs1.
// Latency: ready 2 cycles after valid is sampled (3 for mix ops when MIX_STAGE=1); valid low in SUB/MIX aborts.
// Optional: define AES32_SEQ_DEC_EN to build the inverse S-box and InvMixColumn multipliers (decs/decsm).
module aes32_seq #(
  parameter int MIX_STAGE = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        op_encs,
  input  logic        op_encsm,
  input  logic        op_decs,
  input  logic        op_decsm,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [1:0]  bs,
  output logic [31:0] rd,
  output logic        ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_MIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // GF(2^8) helpers, polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

`ifdef AES32_SEQ_DEC_EN
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction
`endif

  logic [1:0]  state_q, state_d;
  logic [7:0]  s_q, s_d;
  logic [31:0] t_q, t_d;

  // op decode: exactly one op bit must be set, otherwise the op is illegal (t = 0)
  logic [3:0] op_vec;
  logic       one_hot, op_legal, sel_encs, sel_encsm, is_mix, take_mix;
  logic [7:0] b_in, sbox_out;
  logic [31:0] t_comb, t_fin, t_rot;

  assign op_vec    = {op_decsm, op_decs, op_encsm, op_encs};
  assign one_hot   = (op_vec != 4'h0) && ((op_vec & (op_vec - 4'h1)) == 4'h0);
  assign sel_encs  = op_legal & op_encs;
  assign sel_encsm = op_legal & op_encsm;

`ifdef AES32_SEQ_DEC_EN
  logic sel_decs, sel_decsm, is_dec;
  assign op_legal  = one_hot;
  assign sel_decs  = op_legal & op_decs;
  assign sel_decsm = op_legal & op_decsm;
  assign is_dec    = sel_decs | sel_decsm;
  assign is_mix    = sel_encsm | sel_decsm;
`else
  // without the decrypt build, decs/decsm fall into the illegal path
  assign op_legal  = one_hot & (op_encs | op_encsm);
  assign is_mix    = sel_encsm;
`endif

  assign take_mix = (MIX_STAGE != 0) && is_mix;
  assign b_in     = 8'(rs2 >> {bs, 3'b000});

  // shared S-box: one inversion core, affine maps muxed around it for encrypt/decrypt
  always_comb begin
`ifdef AES32_SEQ_DEC_EN
    sbox_out = is_dec ? gf_inv(inv_affine(b_in)) : affine(gf_inv(b_in));
`else
    sbox_out = affine(gf_inv(b_in));
`endif
  end

  // column word built from the registered S-box byte
  always_comb begin
    t_comb = 32'h0;
    if (sel_encsm)
      t_comb = {xtime(s_q) ^ s_q, s_q, s_q, xtime(s_q)};
    else if (sel_encs)
      t_comb = {24'h0, s_q};
`ifdef AES32_SEQ_DEC_EN
    else if (sel_decsm)
      t_comb = {gf_mul(s_q, 8'h0b), gf_mul(s_q, 8'h0d), gf_mul(s_q, 8'h09), gf_mul(s_q, 8'h0e)};
    else if (sel_decs)
      t_comb = {24'h0, s_q};
`endif
  end

  // next-state and datapath loads; each register only loads in its own state
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    t_d     = t_q;
    case (state_q)
      ST_IDLE: if (valid) state_d = ST_SUB;
      ST_SUB: begin
        if (!valid) state_d = ST_IDLE;
        else begin
          s_d     = sbox_out;
          state_d = take_mix ? ST_MIX : ST_DONE;
        end
      end
      ST_MIX: begin
        if (!valid) state_d = ST_IDLE;
        else begin
          t_d     = t_comb;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      s_q     <= 8'h0;
      t_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      t_q     <= t_d;
    end
  end

  // result: rotate the column word into byte position bs and xor into rs1, only in DONE
  always_comb begin
    t_fin = take_mix ? t_q : t_comb;
    case (bs)
      2'd0:    t_rot = t_fin;
      2'd1:    t_rot = {t_fin[23:0], t_fin[31:24]};
      2'd2:    t_rot = {t_fin[15:0], t_fin[31:16]};
      default: t_rot = {t_fin[7:0],  t_fin[31:8]};
    endcase
    ready = (state_q == ST_DONE);
    rd    = ready ? (rs1 ^ t_rot) : 32'h0;
  end

endmodule

// File: tb/tb_aes32_seq.sv
// tb_aes32_seq: randomized scoreboard bench for aes32_seq against a table-driven reference model.
// Stimulus pushes expected {rd, latency}; a negedge monitor pops and compares on every ready.
// Also covers abort in SUB/MIX, reset mid-op, illegal op patterns and back-to-back issue.
module tb_aes32_seq;

  localparam int MIX_STAGE = 1;
`ifdef AES32_SEQ_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic        g_clk, g_resetn, valid;
  logic        op_encs, op_encsm, op_decs, op_decsm;
  logic [31:0] rs1, rs2, rd;
  logic [1:0]  bs;
  logic        ready;

  aes32_seq #(.MIX_STAGE(MIX_STAGE)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid),
    .op_encs(op_encs), .op_encsm(op_encsm), .op_decs(op_decs), .op_decsm(op_decsm),
    .rs1(rs1), .rs2(rs2), .bs(bs), .rd(rd), .ready(ready)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [31:0] rd;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  always @(posedge g_clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h0; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_inv(input logic [7:0] x);
    if (x == 8'h0) return 8'h0;
    for (int y = 1; y < 256; y++)
      if (tb_mul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h0;
  endfunction

  task automatic build_tables();
    logic [7:0] iv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      iv = tb_inv(8'(x));
      for (int j = 0; j < 8; j++)
        s[j] = iv[j] ^ iv[(j+4)%8] ^ iv[(j+5)%8] ^ iv[(j+6)%8] ^ iv[(j+7)%8] ^ c[j];
      sbox_t[x] = s;
      inv_t[s]  = 8'(x);
    end
  endtask

  // op = {decsm, decs, encsm, encs}
  task automatic model(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [1:0] bsel, output logic [31:0] rdv, output int lat);
    logic [7:0]  b, s;
    logic [7:0]  cf [4];
    logic [31:0] t;
    logic [63:0] w;
    bit          legal;
    legal = ($countones(op) == 1) && (op[0] || op[1] || DEC_EN);
    b = r2[8*bsel +: 8];
    s = (op[0] || op[1]) ? sbox_t[b] : inv_t[b];
    cf[3] = 8'h00; cf[2] = 8'h00; cf[1] = 8'h00; cf[0] = 8'h01;
    if (op == 4'b0010) begin cf[3] = 8'h03; cf[2] = 8'h01; cf[1] = 8'h01; cf[0] = 8'h02; end
    if (op == 4'b1000) begin cf[3] = 8'h0b; cf[2] = 8'h0d; cf[1] = 8'h09; cf[0] = 8'h0e; end
    t = legal ? {tb_mul(s, cf[3]), tb_mul(s, cf[2]), tb_mul(s, cf[1]), tb_mul(s, cf[0])} : 32'h0;
    w = {t, t} << (8 * bsel);
    rdv = r1 ^ w[63:32];
    lat = (legal && (op == 4'b0010 || op == 4'b1000) && MIX_STAGE != 0) ? 3 : 2;
  endtask

  // ---------------- monitor ----------------
  always @(negedge g_clk) begin
    exp_t e;
    if (mon_en) begin
      if (ready) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_ready at cycle %0d: ready=1 rd=%h, required no ready", cyc, rd);
        end else begin
          e = sbq.pop_front();
          if (rd !== e.rd) begin
            n_bad++;
            $display("FAIL rd at cycle %0d: got %h, required %h", cyc, rd, e.rd);
          end
          n_cmp++;
          if (cyc - e.cyc != e.lat) begin
            n_bad++;
            $display("FAIL latency at cycle %0d: got %0d, required %0d", cyc, cyc - e.cyc, e.lat);
          end
        end
      end else begin
        n_cmp++;
        if (rd !== 32'h0) begin
          n_bad++;
          $display("FAIL idle_rd at cycle %0d: got %h, required 00000000", cyc, rd);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [1:0] bsel);
    {op_decsm, op_decs, op_encsm, op_encs} = op;
    rs1 = r1; rs2 = r2; bs = bsel; valid = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [1:0] bsel, input bit use_const,
                       input logic [31:0] crd, input int clat);
    exp_t        e;
    logic [31:0] m;
    int          l;
    bit          got;
    @(posedge g_clk); #1;
    drive(op, r1, r2, bsel);
    model(op, r1, r2, bsel, m, l);
    e.rd  = use_const ? crd : m;
    e.lat = use_const ? clat : l;
    e.cyc = cyc;
    sbq.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge g_clk);
      if (ready) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: ready=0 after 8 cycles, required ready for op %b", op);
      sbq.delete();
    end
  endtask

  task automatic release_valid();
    @(posedge g_clk); #1;
    valid = 1'b0;
  endtask

  // mode 0: drop valid in SUB, 1: drop valid in MIX, 2: reset in MIX
  task automatic abort_op(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [1:0] bsel, input int mode);
    @(posedge g_clk); #1;
    drive(op, r1, r2, bsel);
    @(posedge g_clk); #1;
    if (mode == 0) valid = 1'b0;
    else begin
      @(posedge g_clk); #1;
      if (mode == 1) valid = 1'b0;
      else begin
        g_resetn = 1'b0;
        @(posedge g_clk);
        @(negedge g_clk); #1;
        n_cmp++;
        if (ready !== 1'b0 || rd !== 32'h0) begin
          n_bad++;
          $display("FAIL reset_mid_op: ready=%b rd=%h, required ready=0 rd=00000000", ready, rd);
        end
        valid = 1'b0;
        g_resetn = 1'b1;
      end
    end
    repeat (4) @(posedge g_clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    int r, mode;
    g_resetn = 1'b0; valid = 1'b0;
    op_encs = 1'b0; op_encsm = 1'b0; op_decs = 1'b0; op_decsm = 1'b0;
    rs1 = 32'h0; rs2 = 32'h0; bs = 2'd0;
    build_tables();
    repeat (3) @(posedge g_clk);
    #1 mon_en = 1'b1;
    @(posedge g_clk); #1 g_resetn = 1'b1;

    // directed vectors
    issue(4'b0001, 32'h0, 32'h00000053, 2'd0, 1'b1, 32'h000000ED, 2);
    release_valid();
    issue(4'b0010, 32'h0, 32'h00005300, 2'd1, 1'b1, 32'hEDEDC12C, 3);
    release_valid();
    issue(4'b0100, 32'hFFFFFFFF, 32'hED000000, 2'd3, 1'b1,
          DEC_EN ? 32'hACFFFFFF : 32'hFFFFFFFF, 2);
    release_valid();
    issue(4'b1000, 32'h0, 32'h000000ED, 2'd0, 1'b1,
          DEC_EN ? 32'h5BAAFD5F : 32'h0, DEC_EN ? 3 : 2);
    release_valid();
    // illegal patterns: none set, two set
    issue(4'b0000, 32'h12345678, 32'h9abcdef0, 2'd2, 1'b1, 32'h12345678, 2);
    release_valid();
    issue(4'b0011, 32'hCAFEF00D, 32'h00530000, 2'd2, 1'b1, 32'hCAFEF00D, 2);
    release_valid();
    // back-to-back encs with new operands
    issue(4'b0001, 32'h0, 32'h00000053, 2'd0, 1'b0, 32'h0, 0);
    issue(4'b0001, 32'h11111111, 32'h00010000, 2'd2, 1'b0, 32'h0, 0);
    release_valid();
    // aborts and reset mid-op, each followed by a normal op
    abort_op(4'b0001, 32'hAAAA5555, 32'h01020304, 2'd1, 0);
    issue(4'b0010, 32'h0, 32'h00000001, 2'd0, 1'b0, 32'h0, 0);
    release_valid();
    abort_op(4'b0010, 32'h0, 32'h00005300, 2'd1, 1);
    abort_op(4'b0010, 32'h0, 32'h00005300, 2'd1, 2);
    issue(4'b0010, 32'h0, 32'h00005300, 2'd1, 1'b1, 32'hEDEDC12C, 3);
    release_valid();

    // randomized mix
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 9);
      if (mode == 0)
        abort_op(op, $urandom, $urandom, 2'($urandom_range(0, 3)), 0);
      else if (mode == 1)
        abort_op(4'b0010, $urandom, $urandom, 2'($urandom_range(0, 3)), 1);
      else if (mode == 2)
        abort_op(4'b0010, $urandom, $urandom, 2'($urandom_range(0, 3)), 2);
      else begin
        issue(op, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0, 32'h0, 0);
        if ($urandom_range(0, 1) == 0) release_valid();
      end
    end
    release_valid();
    repeat (5) @(posedge g_clk);
    @(negedge g_clk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expected results never seen, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
